// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   uart_state_e     : 2-bit frame FSM encoding (IDLE/START/DATA/STOP)
//   FRAME_BITS       : bits per 8N1 frame (start + 8 data + stop)
//   symbol_edge_time : core clock cycles per bit, integer floor
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO, DEPTH x 8, synchronous write/read, async active-low clear.
//   clk, rst_n       : clock, asynchronous active-low clear
//   wr_en, wr_data   : push request (ignored while full)
//   rd_en            : pop request (ignored while empty, so no bypass)
//   rd_data          : head entry, valid while !empty
//   full, empty      : occupancy flags
//   count            : entries held, 0..DEPTH
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    // DEPTH is a power of two, so the pointers wrap by plain overflow
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmit engine with a small input FIFO.
//   clk            : core clock
//   rst            : asynchronous active-low reset
//   data_in        : byte to send, qualified by data_in_valid
//   data_in_valid  : producer offers a byte
//   data_in_ready  : FIFO has room (depends on FIFO state only)
//   serial_out     : TX line, idles high, driven directly by a flop
//   busy           : frame in progress or bytes queued
//   fifo_count     : bytes queued, excluding the one being shifted
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE      = 115_200,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CPU_CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned SYM_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMBOL_EDGE_TIME - 1);

  uart_state_e      state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;

  logic       fifo_full, fifo_empty, fifo_pop, push;
  logic [7:0] fifo_head;
  logic       sym_done;

  assign data_in_ready = !fifo_full;
  assign push          = data_in_valid && data_in_ready;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (push),
    .wr_data (data_in),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign sym_done = (state_q != IDLE) && (sym_cnt_q == SYM_LAST);

  // A new frame is loaded from IDLE, or straight out of the stop symbol so
  // queued bytes go back-to-back.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == STOP) && sym_done));

  // The shift register LSB is the line itself, so serial_out is a bare flop
  // and never glitches. Vacated bits fill with 1s, leaving the line high.
  assign serial_out = shift_q[0];
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

  // State register (with counters and shift register)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      sym_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      sym_cnt_q <= sym_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (sym_done) state_d = DATA;
      DATA:    if (sym_done && (bit_cnt_q == 4'(FRAME_BITS - 2))) state_d = STOP;
      STOP:    if (sym_done) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    shift_d   = shift_q;
    sym_cnt_d = sym_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (fifo_pop) begin
      shift_d   = {1'b1, fifo_head, 1'b0};
      sym_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (state_q == IDLE) begin
      shift_d   = '1;
      sym_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (sym_done) begin
      shift_d   = {1'b1, shift_q[9:1]};
      sym_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + 4'd1;
    end else begin
      sym_cnt_d = sym_cnt_q + SYM_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 10 cycles/bit, FIFO_DEPTH=4.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       busy;
  logic [2:0] fifo_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] t3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] t4 [6] = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hA6, 8'h5E};

  always #5 clk = ~clk;

  uart_transmitter #(
    .CPU_CLOCK_FREQ (1_000_000),
    .BAUD_RATE      (100_000),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) tick();
  endtask

  // Entered 'already' edges after a start-bit edge; samples each bit at
  // mid-symbol and returns at the frame-end edge (start + 100).
  task automatic expect_frame(input string tag, input int unsigned already,
                              input logic [7:0] b);
    logic [9:0] got;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) ticks(5 - already);
      else        ticks(10);
      got[k] = serial_out;
    end
    ticks(5);
    check(tag, 32'(got), 32'({1'b1, b, 1'b0}));
  endtask

  initial begin
    int unsigned lows;

    // Reset state, asynchronously before any clock edge
    #1 rst = 1'b0;
    #1;
    check("rst_serial", 32'(serial_out), 1);
    check("rst_busy",   32'(busy), 0);
    check("rst_count",  32'(fifo_count), 0);
    check("rst_ready",  32'(data_in_ready), 1);
    ticks(3);
    check("rst_hold_serial", 32'(serial_out), 1);
    rst = 1'b1;
    ticks(2);

    // 1. Single byte A5
    data_in = 8'hA5; data_in_valid = 1'b1;
    tick();                                   // edge N
    data_in_valid = 1'b0;
    check("t1_count_n",  32'(fifo_count), 1);
    check("t1_serial_n", 32'(serial_out), 1);
    tick();                                   // N+1
    check("t1_start",    32'(serial_out), 0);
    check("t1_count_n1", 32'(fifo_count), 0);
    check("t1_busy",     32'(busy), 1);
    expect_frame("t1_frame", 0, 8'hA5);       // ends at N+101
    check("t1_end_serial", 32'(serial_out), 1);
    check("t1_end_busy",   32'(busy), 0);

    // 2. Back-to-back 55, 0F, FF
    data_in = 8'h55; data_in_valid = 1'b1;
    tick();                                   // N
    check("t2_count_n", 32'(fifo_count), 1);
    data_in = 8'h0F;
    tick();                                   // N+1: pop + push
    check("t2_count_n1", 32'(fifo_count), 1);
    check("t2_start1",   32'(serial_out), 0);
    data_in = 8'hFF;
    tick();                                   // N+2
    data_in_valid = 1'b0;
    check("t2_count_peak", 32'(fifo_count), 2);
    expect_frame("t2_frame1", 1, 8'h55);      // N+101
    check("t2_start2",  32'(serial_out), 0);
    check("t2_count_2", 32'(fifo_count), 1);
    expect_frame("t2_frame2", 0, 8'h0F);      // N+201
    check("t2_start3",  32'(serial_out), 0);
    check("t2_count_3", 32'(fifo_count), 0);
    expect_frame("t2_frame3", 0, 8'hFF);      // N+301
    check("t2_end_serial", 32'(serial_out), 1);
    check("t2_end_busy",   32'(busy), 0);

    // 3. Full FIFO: valid held 6 edges, 5 accepted
    data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = t3[i];
      tick();
    end
    check("t3_count_full", 32'(fifo_count), 4);
    check("t3_ready_full", 32'(data_in_ready), 0);
    data_in = t3[5];
    tick();                                   // refused
    data_in_valid = 1'b0;
    check("t3_count_after", 32'(fifo_count), 4);
    check("t3_ready_after", 32'(data_in_ready), 0);
    expect_frame("t3_frame0", 4, t3[0]);
    for (int j = 1; j < 5; j++) expect_frame("t3_frame", 0, t3[j]);
    check("t3_end_busy",  32'(busy), 0);
    check("t3_end_count", 32'(fifo_count), 0);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (serial_out !== 1'b1) lows++;
    end
    check("t3_no_refused_frame", lows, 0);

    // 4. Push offered on the stop-bit terminal edge while full
    data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = t4[i];
      tick();
    end
    data_in_valid = 1'b0;
    check("t4_count_full", 32'(fifo_count), 4);
    ticks(96);                                // S+99
    data_in = t4[5]; data_in_valid = 1'b1;
    check("t4_ready_pre", 32'(data_in_ready), 0);
    check("t4_stop_bit",  32'(serial_out), 1);
    tick();                                   // S+100: pop, push refused
    check("t4_count_pop",  32'(fifo_count), 3);
    check("t4_ready_pop",  32'(data_in_ready), 1);
    check("t4_next_start", 32'(serial_out), 0);
    tick();                                   // S+101: accepted
    data_in_valid = 1'b0;
    check("t4_count_refill", 32'(fifo_count), 4);
    expect_frame("t4_frame1", 1, t4[1]);
    for (int j = 2; j < 6; j++) expect_frame("t4_frame", 0, t4[j]);
    check("t4_end_serial", 32'(serial_out), 1);
    check("t4_end_busy",   32'(busy), 0);

    // 5. Reset during DATA bit 3
    data_in = 8'h00; data_in_valid = 1'b1;
    tick();                                   // P
    data_in = 8'h3C;
    tick();                                   // P+1 = S
    data_in_valid = 1'b0;
    ticks(44);                                // inside bit 3
    check("t5_pre_serial", 32'(serial_out), 0);
    check("t5_pre_busy",   32'(busy), 1);
    check("t5_pre_count",  32'(fifo_count), 1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_serial", 32'(serial_out), 1);
    check("t5_rst_busy",   32'(busy), 0);
    check("t5_rst_count",  32'(fifo_count), 0);
    check("t5_rst_ready",  32'(data_in_ready), 1);
    ticks(2);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (serial_out !== 1'b1) lows++;
    end
    check("t5_no_residual", lows, 0);
    check("t5_post_busy",   32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial transmit engine that drives FPGA_SERIAL_TX of the Riscv151 core. It is the transmit-side counterpart of the on-chip UART receiver that samples FPGA_SERIAL_RX.
- The memory-mapped UART data register pushes bytes through a ready/valid port into a small FIFO.
- The engine serialises each byte as 8N1: one start bit, 8 data bits LSB first, one stop bit.
- Bit timing is derived from CPU_CLOCK_FREQ.

Parameters:
CPU_CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
BAUD_RATE, 115_200, line rate in bits/s.
FIFO_DEPTH, 4, transmit FIFO entries; power of two, at least 2.

Ports:
clk  input  1  core clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
data_in  input  8  byte to transmit.
data_in_valid  input  1  producer has a byte on data_in.
data_in_ready  output  1  FIFO can accept a byte.
serial_out  output  1  TX line; idles high.
busy  output  1  FIFO non-empty or frame in progress.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.

Behaviour:
- SYMBOL_EDGE_TIME = CPU_CLOCK_FREQ / BAUD_RATE, integer floor. Every bit is held for exactly SYMBOL_EDGE_TIME cycles. Defaults give 434 cycles.
- Reset (rst=0, asynchronous):
  - serial_out=1, busy=0, fifo_count=0, FSM=IDLE.
  - Bit counter, symbol counter and FIFO pointers are cleared.
  - data_in_ready=1 while in reset.
  - Reset mid-frame aborts the frame immediately; the line returns high with no stop bit emitted, and queued bytes are discarded.
- Handshake:
  - A byte is accepted on a posedge where data_in_valid && data_in_ready.
  - data_in_ready = (fifo_count != FIFO_DEPTH). It is a function of FIFO state only, never of same-cycle pops.
  - While full, a push is refused even if a pop occurs on the same edge.
  - data_in is don't-care when data_in_valid=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: serial_out=1. On an edge with fifo_count!=0, pop the head into a 10-bit shift register {1, byte, 0}, clear the counters, go to START. serial_out=0 is registered on that same edge.
  - START, DATA, STOP: the symbol counter counts 0..SYMBOL_EDGE_TIME-1. At terminal count the register shifts right and the bit counter increments; serial_out is driven from the shift register LSB (registered).
  - DATA covers 8 bits. STOP lasts one symbol.
- End of STOP symbol:
  - If the FIFO is non-empty, pop and enter START on the same edge. Frames go back-to-back with no idle cycles.
  - Otherwise go to IDLE.
- Latency:
  - A byte accepted on edge N into an empty FIFO with the FSM in IDLE drives the start bit from edge N+1.
  - The full frame is 10*SYMBOL_EDGE_TIME cycles; serial_out is high again at edge N+1+10*SYMBOL_EDGE_TIME.
- FIFO:
  - No bypass: an empty FIFO cannot be pushed and popped on the same edge.
  - Push and pop on the same edge with 0<count<FIFO_DEPTH leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (state != IDLE) || (fifo_count != 0). It is combinational from registers.
- serial_out is glitch-free: it comes straight from a flop.

Decomposition:
- Shared uart package holds:
  - the FSM state encoding: 2-bit IDLE=0, START=1, DATA=2, STOP=3;
  - a function computing SYMBOL_EDGE_TIME from CPU_CLOCK_FREQ and BAUD_RATE;
  - the frame-length constant 10.
- The receiver uses the same symbol function.
- One sub-module, uart_tx_fifo: parameterised FIFO_DEPTH x 8, synchronous write/read with async active-low clear, exposing full, empty and count.
- The FSM, counters and shift register stay in uart_transmitter.

Test Plan:
All cases use CPU_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, giving 10 cycles/bit.
1. Single byte: push 8'hA5 at edge N. serial_out low from N+1. It then samples, at mid-bit N+1+5+10k for k=0..9, the sequence 0,1,0,1,0,0,1,0,1,1. It is high at N+101 and busy=0 from then on.
2. Back-to-back: push 8'h55, 8'h0F, 8'hFF on consecutive edges. fifo_count peaks at 2. The three frames are contiguous: second start bit at N+101, third at N+201, with no extra high cycles between stop and start.
3. Full FIFO: with FIFO_DEPTH=4, hold valid for 6 consecutive edges while the engine is busy.
   - Exactly 5 bytes are accepted: 1 popped by the engine, 4 queued.
   - data_in_ready=0 while fifo_count=4.
   - The refused bytes never appear on serial_out.
   - The output order matches push order.
4. Push on pop edge: fill to count 4, then assert valid on the stop-bit terminal edge. The push is refused because ready=0. The next edge accepts it and fifo_count returns to 4.
5. Reset mid-frame: after pushing 8'h00 and 8'h3C, assert rst=0 during DATA bit 3 between clock edges. serial_out=1, busy=0 and fifo_count=0 take effect immediately, before the next clock. After release the line stays high with no residual frame.
